f1_start_sequencer: RTL and testbench
=====================================

Name: f1_start_sequencer

Overview:
Parametrised start-light controller and driver reaction timer.
- Lights N_LIGHTS lamps one at a time, paced by `tick`.
- Holds all lamps lit for a pseudo-random delay, then switches them all off.
- Measures driver reaction from lights-out to `button`, in ticks.
- Flags jump starts (button pressed before lights-out) and no-press timeouts.
- Sits between the tick divider and the LED/7-seg display logic.

Parameters:
N_LIGHTS, 10, number of lamps driven on `ledr`.
LIGHT_PERIOD, 500, ticks between successive lamps lighting (>=1).
MIN_DELAY, 200, minimum all-lit hold, in ticks (>=1).
RAND_W, 10, random bits added to MIN_DELAY; hold = MIN_DELAY + lfsr[RAND_W-1:0] (RAND_W<=16).
RT_W, 14, width of the reaction-time counter.
LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero).

Ports:
sysclk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
tick  in  1  one-cycle pacing strobe (1 ms nominal).
trigger  in  1  start request; level, sampled every cycle.
button  in  1  driver button; synchronised and level-sampled upstream.
ledr  out  N_LIGHTS  lamp drive; bit N_LIGHTS-1 lights first.
busy  out  1  high in COUNT, DELAY and REACT.
result_valid  out  1  one-cycle pulse when a run finishes (DONE or JUMP entered).
reaction_time  out  RT_W  latched reaction in ticks; held until the next result.
jump_start  out  1  high while in JUMP.
timeout  out  1  high while in DONE if the run ended by saturation.

Behaviour:
- Reset values: state IDLE; ledr=0; busy=0; result_valid=0; reaction_time=0; jump_start=0; timeout=0; LFSR=LFSR_SEED; internal counters 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle regardless of state, and also during reset-release cycles after the first.
- States: IDLE, COUNT, DELAY, REACT, DONE, JUMP.
- IDLE/DONE/JUMP with trigger=1:
  - Next state is COUNT.
  - Clear ledr, light index and tick counter.
  - Clear jump_start and timeout; reaction_time keeps its old value.
- trigger is ignored in COUNT, DELAY and REACT.
- COUNT:
  - Tick counter counts ticks.
  - On the LIGHT_PERIOD-th tick: set ledr[N_LIGHTS-1-k], k++, clear tick counter.
  - When k reaches N_LIGHTS (the last lamp lights on the same edge): go to DELAY.
  - On that edge, load delay_cnt = MIN_DELAY + lfsr[RAND_W-1:0], using the LFSR value in that cycle.
- DELAY:
  - delay_cnt decrements on each tick.
  - On the tick where delay_cnt==1: ledr<=0, go to REACT, rt_cnt<=0.
- REACT:
  - rt_cnt increments on each tick and saturates at 2^RT_W-1.
  - button=1: go to DONE; reaction_time<=rt_cnt (value before any same-cycle increment); result_valid pulse.
  - Button in the first REACT cycle gives reaction_time=0.
  - rt_cnt at saturation with no button: go to DONE; timeout=1; reaction_time=all-ones; result_valid pulse.
- button=1 in any cycle while in COUNT or DELAY:
  - Go to JUMP; ledr<=0; jump_start=1; reaction_time<=0; result_valid pulse.
  - This includes the cycle in which the final DELAY tick arrives: jump has priority over lights-out.
- Arithmetic:
  - Delay sum is computed at width max(16, clog2(MIN_DELAY)+1)+1; no overflow.
  - The light index is clog2(N_LIGHTS+1) bits wide.
- Events without a tick do not advance the tick-paced counters.
- Reset mid-run forces the reset state on the next edge; no partial result is reported.

Decomposition:
- Package f1_pkg:
  - state enum f1_state_t {IDLE, COUNT, DELAY, REACT, DONE, JUMP};
  - LFSR polynomial constant F1_LFSR_TAPS = 16'hB400.
- One sub-module, f1_lfsr (ports: sysclk, reset, q[15:0]; parameter SEED), instantiated once.

Test Plan:
- Bench parameters: N_LIGHTS=5, LIGHT_PERIOD=2, MIN_DELAY=3, RAND_W=1, tick tied high.
- Reset held 3 cycles -> all outputs 0 and state IDLE; trigger=1 during reset -> no effect.
- Normal run:
  - Stimulus: trigger pulse, then button 4 cycles after lights-out.
  - ledr goes 10000, 11000, ..., 11111, one step every 2 cycles.
  - All-lit hold lasts 3 or 4 cycles, matching the bench LFSR model.
  - Then ledr=00000 and reaction_time=4 with a 1-cycle result_valid.
- Jump start: button during DELAY -> next cycle jump_start=1, ledr=0, reaction_time=0, result_valid pulse; trigger restarts COUNT and clears jump_start.
- Simultaneous: button on the final DELAY tick -> JUMP, not REACT.
- Timeout: RT_W=4, no button -> after 15 ticks in REACT: timeout=1, reaction_time=4'hF, result_valid pulse.
- Reset asserted mid-COUNT with 3 lamps lit -> next cycle ledr=0, busy=0, no result_valid.

Source files
------------

// File: rtl/f1_start_sequencer_pkg.sv
// f1_pkg: shared types for the F1 start sequencer.
// FSM state enum, LFSR taps and the LFSR step function.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DELAY,
    REACT,
    DONE,
    JUMP
  } f1_state_t;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] F1_LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] f1_lfsr_next(
    input logic [15:0] q
  );
    return (q >> 1) ^ (q[0] ? F1_LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/f1_start_sequencer_if.sv
// f1_start_sequencer_if: pacing/driver inputs and lamp/result outputs.
// master drives tick/trigger/button; slave (the sequencer) drives the rest.
interface f1_start_sequencer_if #(
  parameter int N_LIGHTS = 10,
  parameter int RT_W     = 14
);

  logic                tick;
  logic                trigger;
  logic                button;
  logic [N_LIGHTS-1:0] ledr;
  logic                busy;
  logic                result_valid;
  logic [RT_W-1:0]     reaction_time;
  logic                jump_start;
  logic                timeout;

  modport master (
    output tick, trigger, button,
    input  ledr, busy, result_valid,
    input  reaction_time, jump_start, timeout
  );

  modport slave (
    input  tick, trigger, button,
    output ledr, busy, result_valid,
    output reaction_time, jump_start, timeout
  );

endinterface

// File: rtl/f1_start_sequencer_lfsr.sv
// f1_lfsr: free-running 16-bit Galois LFSR for the random hold.
// Ports: sysclk, reset (sync, active high), q (current state).
module f1_lfsr
  import f1_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge sysclk) begin
    if (reset) q <= SEED;
    else       q <= f1_lfsr_next(q);
  end

endmodule

// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer: start-light sequence plus driver reaction timer.
// Ports: sysclk, reset (sync, active high), bus (slave: tick/trigger/button in, lamps/result out).
module f1_start_sequencer
  import f1_pkg::*;
#(
  parameter int          N_LIGHTS     = 10,
  parameter int          LIGHT_PERIOD = 500,
  parameter int          MIN_DELAY    = 200,
  parameter int          RAND_W       = 10,
  parameter int          RT_W         = 14,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic               sysclk,
  input logic               reset,
  f1_start_sequencer_if.slave bus
);

  localparam int MDW = $clog2(MIN_DELAY) + 1;
  localparam int DW  = ((MDW > 16) ? MDW : 16) + 1;
  localparam int KW  = $clog2(N_LIGHTS + 1);
  localparam int PW  = $clog2(LIGHT_PERIOD + 1);

  localparam logic [RT_W-1:0]     RT_MAX   = '1;
  localparam logic [N_LIGHTS-1:0] TOP_LAMP =
    N_LIGHTS'(1) << (N_LIGHTS - 1);

  f1_state_t           state_q, state_d;
  logic [N_LIGHTS-1:0] ledr_q, ledr_d;
  logic [KW-1:0]       k_q, k_d;
  logic [PW-1:0]       tcnt_q, tcnt_d;
  logic [DW-1:0]       dly_q, dly_d;
  logic [RT_W-1:0]     rt_q, rt_d;
  logic [RT_W-1:0]     rtime_q, rtime_d;
  logic                rv_q, rv_d;
  logic                js_q, js_d;
  logic                to_q, to_d;
  logic [15:0]         lfsr_q;
  logic                jump;

  f1_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .sysclk(sysclk),
    .reset (reset),
    .q     (lfsr_q)
  );

  if (RAND_W < 16) begin : g_lfsr_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_q[15:RAND_W];
  end

  // A press before lights-out beats any same-cycle lamp/tick event
  assign jump = bus.button &&
    (state_q == COUNT || state_q == DELAY);

  always_comb begin
    state_d = state_q;
    ledr_d  = ledr_q;
    k_d     = k_q;
    tcnt_d  = tcnt_q;
    dly_d   = dly_q;
    rt_d    = rt_q;
    rtime_d = rtime_q;
    rv_d    = 1'b0;
    js_d    = js_q;
    to_d    = to_q;
    if (jump) begin
      state_d = JUMP;
      ledr_d  = '0;
      js_d    = 1'b1;
      rtime_d = '0;
      rv_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE, JUMP: begin
          if (bus.trigger) begin
            state_d = COUNT;
            ledr_d  = '0;
            k_d     = '0;
            tcnt_d  = '0;
            js_d    = 1'b0;
            to_d    = 1'b0;
          end
        end
        COUNT: begin
          if (bus.tick) begin
            if (tcnt_q == PW'(LIGHT_PERIOD - 1)) begin
              tcnt_d = '0;
              ledr_d = (ledr_q >> 1) | TOP_LAMP;
              k_d    = k_q + KW'(1);
              if (k_q == KW'(N_LIGHTS - 1)) begin
                state_d = DELAY;
                dly_d   = DW'(MIN_DELAY) +
                          DW'(lfsr_q[RAND_W-1:0]);
              end
            end else begin
              tcnt_d = tcnt_q + PW'(1);
            end
          end
        end
        DELAY: begin
          if (bus.tick) begin
            if (dly_q == DW'(1)) begin
              state_d = REACT;
              ledr_d  = '0;
              rt_d    = '0;
            end else begin
              dly_d = dly_q - DW'(1);
            end
          end
        end
        REACT: begin
          if (bus.button) begin
            state_d = DONE;
            rtime_d = rt_q;
            rv_d    = 1'b1;
          end else if (rt_q == RT_MAX) begin
            state_d = DONE;
            rtime_d = RT_MAX;
            to_d    = 1'b1;
            rv_d    = 1'b1;
          end else if (bus.tick) begin
            rt_d = rt_q + RT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= IDLE;
      ledr_q  <= '0;
      k_q     <= '0;
      tcnt_q  <= '0;
      dly_q   <= '0;
      rt_q    <= '0;
      rtime_q <= '0;
      rv_q    <= 1'b0;
      js_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ledr_q  <= ledr_d;
      k_q     <= k_d;
      tcnt_q  <= tcnt_d;
      dly_q   <= dly_d;
      rt_q    <= rt_d;
      rtime_q <= rtime_d;
      rv_q    <= rv_d;
      js_q    <= js_d;
      to_q    <= to_d;
    end
  end

  assign bus.ledr          = ledr_q;
  assign bus.busy          = (state_q == COUNT) ||
                             (state_q == DELAY) ||
                             (state_q == REACT);
  assign bus.result_valid  = rv_q;
  assign bus.reaction_time = rtime_q;
  assign bus.jump_start    = js_q;
  assign bus.timeout       = to_q;

endmodule

// File: tb/tb_f1_start_sequencer.sv
// tb_f1_start_sequencer: randomized self-checking bench for f1_start_sequencer.
// N_LIGHTS=5, LIGHT_PERIOD=2, MIN_DELAY=3, RAND_W=1, RT_W=4.
module tb_f1_start_sequencer;

  localparam int          NL   = 5;
  localparam int          LP   = 2;
  localparam int          MD   = 3;
  localparam int          RW   = 1;
  localparam int          RTW  = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0]    m_lfsr;
  logic [15:0]    m_prev;
  logic [RTW-1:0] m_rt;

  always #5 sysclk = ~sysclk;

  f1_start_sequencer_if #(.N_LIGHTS(NL), .RT_W(RTW)) bus ();

  f1_start_sequencer #(
    .N_LIGHTS    (NL),
    .LIGHT_PERIOD(LP),
    .MIN_DELAY   (MD),
    .RAND_W      (RW),
    .RT_W        (RTW),
    .LFSR_SEED   (SEED)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1; m_prev is the value
  // that was visible during the cycle before the latest edge.
  always @(posedge sysclk) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= SEED;
    else m_lfsr <= {1'b0, m_lfsr[15:1]} ^
                   (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Lamps fill from the MSB: n lit lamps.
  function automatic logic [NL-1:0] lamps(input int n);
    logic [NL-1:0] m;
    m = '0;
    for (int i = 0; i < n && i < NL; i++) m[NL-1-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [NL+RTW+3:0] obs();
    return {bus.ledr, bus.busy, bus.result_valid,
            bus.jump_start, bus.timeout, bus.reaction_time};
  endfunction

  function automatic logic [NL+RTW+3:0] exp_v(
    input logic [NL-1:0] l, input logic b, input logic rv,
    input logic js, input logic to, input logic [RTW-1:0] rt
  );
    return {l, b, rv, js, to, rt};
  endfunction

  task automatic start_run(input string nm);
    logic [NL+RTW+3:0] e;
    bus.trigger = 1'b1;
    @(negedge sysclk);
    bus.trigger = 1'b0;
    e = exp_v('0, 1'b1, 1'b0, 1'b0, 1'b0, m_rt);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL %s_start got=%h exp=%h", nm, obs(), e);
    end
  endtask

  // Walk the lamp sequence up to the all-lit cycle (or stop at c=upto).
  task automatic climb(input string nm, input int upto, output int hold);
    logic [NL+RTW+3:0] e;
    for (int c = 1; c <= upto; c++) begin
      @(negedge sysclk);
      e = exp_v(lamps(c / LP), 1'b1, 1'b0, 1'b0, 1'b0, m_rt);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s_climb c=%0d got=%h exp=%h",
                 nm, c, obs(), e);
      end
    end
    hold = MD + int'(m_prev[RW-1:0]);
  endtask

  task automatic hold_lit(input string nm, input int n);
    logic [NL+RTW+3:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      e = exp_v(lamps(NL), 1'b1, 1'b0, 1'b0, 1'b0, m_rt);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s_hold i=%0d got=%h exp=%h",
                 nm, i, obs(), e);
      end
    end
  endtask

  task automatic test_reset();
    logic [NL+RTW+3:0] e;
    reset = 1'b1;
    bus.trigger = 1'b1;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    reset = 1'b0;
    bus.trigger = 1'b0;
    m_rt = '0;
    @(negedge sysclk);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_normal();
    logic [NL+RTW+3:0] e;
    int hold;
    int dly;
    for (int r = 0; r < 6; r++) begin
      dly = $urandom_range(0, 12);
      start_run("normal");
      climb("normal", NL * LP, hold);
      hold_lit("normal", hold - 1);
      for (int i = 0; i <= dly; i++) begin
        @(negedge sysclk);
        e = exp_v('0, 1'b1, 1'b0, 1'b0, 1'b0, m_rt);
        checks++;
        if (obs() !== e) begin
          failures++;
          $display("FAIL normal_react i=%0d got=%h exp=%h",
                   i, obs(), e);
        end
      end
      bus.button = 1'b1;
      @(negedge sysclk);
      bus.button = 1'b0;
      m_rt = RTW'(dly);
      e = exp_v('0, 1'b0, 1'b1, 1'b0, 1'b0, m_rt);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL normal_result dly=%0d got=%h exp=%h",
                 dly, obs(), e);
      end
      @(negedge sysclk);
      e = exp_v('0, 1'b0, 1'b0, 1'b0, 1'b0, m_rt);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL normal_pulse got=%h exp=%h", obs(), e);
      end
    end
  endtask

  task automatic check_jump(input string nm);
    logic [NL+RTW+3:0] e;
    @(negedge sysclk);
    bus.button = 1'b0;
    m_rt = '0;
    e = exp_v('0, 1'b0, 1'b1, 1'b1, 1'b0, m_rt);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL %s_jump got=%h exp=%h", nm, obs(), e);
    end
    @(negedge sysclk);
    e = exp_v('0, 1'b0, 1'b0, 1'b1, 1'b0, m_rt);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL %s_jump_hold got=%h exp=%h", nm, obs(), e);
    end
  endtask

  task automatic test_jump_count();
    int hold;
    int n;
    n = $urandom_range(1, NL * LP - 1);
    start_run("jcount");
    climb("jcount", n, hold);
    bus.button = 1'b1;
    check_jump("jcount");
  endtask

  task automatic test_jump_delay();
    int hold;
    int k;
    start_run("jdelay");
    climb("jdelay", NL * LP, hold);
    k = $urandom_range(0, hold - 2);
    hold_lit("jdelay", k);
    bus.button = 1'b1;
    check_jump("jdelay");
  endtask

  // Press lands on the edge of the final hold tick.
  task automatic test_simultaneous();
    int hold;
    start_run("simul");
    climb("simul", NL * LP, hold);
    hold_lit("simul", hold - 1);
    bus.button = 1'b1;
    check_jump("simul");
  endtask

  task automatic test_timeout();
    logic [NL+RTW+3:0] e;
    int hold;
    start_run("tmo");
    climb("tmo", NL * LP, hold);
    hold_lit("tmo", hold - 1);
    for (int i = 0; i <= 15; i++) begin
      @(negedge sysclk);
      e = exp_v('0, 1'b1, 1'b0, 1'b0, 1'b0, m_rt);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL tmo_react i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    @(negedge sysclk);
    m_rt = 4'hF;
    e = exp_v('0, 1'b0, 1'b1, 1'b0, 1'b1, m_rt);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL tmo_result got=%h exp=%h", obs(), e);
    end
  endtask

  // Restart from DONE/timeout keeps reaction_time, clears timeout;
  // no lamp advances while tick is low.
  task automatic test_tick_gate();
    logic [NL+RTW+3:0] e;
    int hold;
    int n;
    start_run("tgate");
    bus.tick = 1'b0;
    n = $urandom_range(2, 6);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      e = exp_v('0, 1'b1, 1'b0, 1'b0, 1'b0, m_rt);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL tgate_idle i=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    bus.tick = 1'b1;
    climb("tgate", 3 * LP, hold);
  endtask

  task automatic test_reset_mid();
    logic [NL+RTW+3:0] e;
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    m_rt = '0;
    e = '0;
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", obs(), e);
    end
    @(negedge sysclk);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_mid_idle got=%h exp=%h", obs(), e);
    end
  endtask

  initial begin
    bus.tick    = 1'b1;
    bus.trigger = 1'b0;
    bus.button  = 1'b0;
    m_rt        = '0;
    test_reset();
    test_normal();
    test_jump_count();
    test_jump_delay();
    test_simultaneous();
    test_timeout();
    test_tick_gate();
    test_reset_mid();
    test_normal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
